audio_decimator: RTL and testbench



---
 rtl/audio_decimator.sv | 143 ++++++++++++++
 tb/tb_audio_decimator.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/audio_decimator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : audio_decimator                                               |
// | Brief    : Two 4-bit TIA audio levels -> 15-bit signed PCM at RATE_HZ.   |
// |            A fractional phase accumulator issues one tick per output     |
// |            period. A 512-sample box filter integrates the input, and the |
// |            DC offset is removed before the result is registered.         |
// | Options  : AUDIO_DECIMATOR_STEREO_EN - build one accumulator per channel |
// |            (aud0 -> audio_l, aud1 -> audio_r). When it is undefined, a   |
// |            single accumulator integrates the mono mix aud0 + aud1, and   |
// |            both outputs carry that same value.                           |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module audio_decimator #(
  parameter int CLK_HZ  = 28542800,
  parameter int RATE_HZ = 48000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  aud0,
  input  logic [3:0]  aud1,
  output logic [14:0] audio_l,
  output logic [14:0] audio_r,
  output logic        sample_stb
);

  localparam logic [25:0] c_clk_hz  = 26'(CLK_HZ);
  localparam logic [25:0] c_rate_hz = 26'(RATE_HZ);
  localparam logic [9:0]  c_win_len = 10'd512;

  logic [24:0]        r_ph;
  logic [25:0]        w_ph_sum;
  logic               w_tick;
  logic [9:0]         r_wcnt;
  logic               w_full;
  logic               w_load;
  logic signed [14:0] w_pcm_l;
  logic signed [14:0] w_pcm_r;
  logic [14:0]        r_audio_l;
  logic [14:0]        r_audio_r;
  logic               r_sample_stb;

  // The phase sum is one bit wider than ph so that it cannot wrap before the compare.
  assign w_ph_sum = {1'b0, r_ph} + c_rate_hz;
  assign w_tick   = (w_ph_sum >= c_clk_hz);
  assign w_full   = (r_wcnt == c_win_len);
  // Only a complete window may produce a sample. A partial window exists only after reset.
  assign w_load   = w_tick && w_full;

  // Fractional-rate phase accumulator. It wraps by CLK_HZ on each tick, so the long-run rate is exact.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ph <= '0;
    end else if (w_tick) begin
      r_ph <= 25'(w_ph_sum - c_clk_hz);
    end else begin
      r_ph <= w_ph_sum[24:0];
    end
  end

  // Window sample counter. It saturates at 512 and restarts on every tick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wcnt <= '0;
    end else if (w_tick) begin
      r_wcnt <= '0;
    end else if (!w_full) begin
      r_wcnt <= r_wcnt + 10'd1;
    end
  end

`ifdef AUDIO_DECIMATOR_STEREO_EN
  // Stereo: one accumulator per channel. Each channel sums at most 512 * 15 = 7680.
  logic [13:0]        r_acc0;
  logic [13:0]        r_acc1;
  logic signed [14:0] w_diff0;
  logic signed [14:0] w_diff1;

  // Per-channel box-filter integrators. The sample taken on a tick cycle is discarded.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc0 <= '0;
      r_acc1 <= '0;
    end else if (w_tick) begin
      r_acc0 <= '0;
      r_acc1 <= '0;
    end else if (!w_full) begin
      r_acc0 <= r_acc0 + {10'd0, aud0};
      r_acc1 <= r_acc1 + {10'd0, aud1};
    end
  end

  // Mid-scale is 3840. The result spans +/-3840, and << 2 scales it to +/-15360.
  assign w_diff0 = $signed({1'b0, r_acc0}) - 15'sd3840;
  assign w_diff1 = $signed({1'b0, r_acc1}) - 15'sd3840;
  assign w_pcm_l = w_diff0 <<< 2;
  assign w_pcm_r = w_diff1 <<< 2;
`else
  // Mono: the mix is 0..30 per cycle, so a full window sums to at most 15360.
  logic [4:0]         w_mix;
  logic [13:0]        r_acc;
  logic signed [14:0] w_diff;

  assign w_mix = {1'b0, aud0} + {1'b0, aud1};

  // Mono box-filter integrator. The sample taken on a tick cycle is discarded.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc <= '0;
    end else if (w_tick) begin
      r_acc <= '0;
    end else if (!w_full) begin
      r_acc <= r_acc + {9'd0, w_mix};
    end
  end

  // Mid-scale is 7680. The result spans +/-7680, and << 1 scales it to +/-15360.
  assign w_diff  = $signed({1'b0, r_acc}) - 15'sd7680;
  assign w_pcm_l = w_diff <<< 1;
  assign w_pcm_r = w_diff <<< 1;
`endif

  // Output register stage. PCM updates only together with its one-cycle strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_audio_l    <= '0;
      r_audio_r    <= '0;
      r_sample_stb <= 1'b0;
    end else begin
      r_sample_stb <= w_load;
      if (w_load) begin
        r_audio_l <= w_pcm_l;
        r_audio_r <= w_pcm_r;
      end
    end
  end

  assign audio_l    = r_audio_l;
  assign audio_r    = r_audio_r;
  assign sample_stb = r_sample_stb;

endmodule
`default_nettype wire

// File: tb/tb_audio_decimator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_audio_decimator                                            |
// | Brief    : Directed self-checking bench for audio_decimator. It uses a   |
// |            default-rate instance and a second instance at 6000 Hz / 10 Hz|
// |            for the exact-period check.                                   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_audio_decimator;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        rst_n_s;
  logic [3:0]  aud0;
  logic [3:0]  aud1;
  logic [14:0] audio_l;
  logic [14:0] audio_r;
  logic        sample_stb;
  logic [14:0] s_l;
  logic [14:0] s_r;
  logic        s_stb;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  audio_decimator dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .aud0       (aud0),
    .aud1       (aud1),
    .audio_l    (audio_l),
    .audio_r    (audio_r),
    .sample_stb (sample_stb)
  );

  audio_decimator #(.CLK_HZ(6000), .RATE_HZ(10)) dut_s (
    .clk        (clk),
    .reset_n    (rst_n_s),
    .aud0       (aud0),
    .aud1       (aud1),
    .audio_l    (s_l),
    .audio_r    (s_r),
    .sample_stb (s_stb)
  );

  // Full-window expectations, derived by hand from the scaling rules.
  // Mono:   (512*(a0+a1) - 7680)*2 = 1024*(a0+a1) - 15360
  // Stereo: (512*a - 3840)*4       = 2048*a - 15360
  function automatic logic [14:0] exp_l(input int a0, input int a1);
`ifdef AUDIO_DECIMATOR_STEREO_EN
    return 15'(2048 * a0 - 15360);
`else
    return 15'(1024 * (a0 + a1) - 15360);
`endif
  endfunction

  function automatic logic [14:0] exp_r(input int a0, input int a1);
`ifdef AUDIO_DECIMATOR_STEREO_EN
    return 15'(2048 * a1 - 15360);
`else
    return 15'(1024 * (a0 + a1) - 15360);
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Count edges until sample_stb is seen. On timeout, n is -1.
  task automatic wait_stb(output int n);
    bit found;
    found = 1'b0;
    n = -1;
    for (int i = 1; i <= 2000; i++) begin
      if (!found) begin
        step();
        if (sample_stb) begin
          found = 1'b1;
          n = i;
        end
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    rst_n_s = 1'b0;
    aud0 = 4'd15;
    aud1 = 4'd15;
    repeat (3) @(negedge clk);
    checks++; if (audio_l !== 15'd0) begin errors++; $display("FAIL reset_l got=%h want=%h", audio_l, 15'd0); end
    checks++; if (audio_r !== 15'd0) begin errors++; $display("FAIL reset_r got=%h want=%h", audio_r, 15'd0); end
    checks++; if (sample_stb !== 1'b0) begin errors++; $display("FAIL reset_stb got=%b want=0", sample_stb); end
  endtask

  task automatic test_first_strobe();
    int n;
    @(negedge clk);
    reset_n = 1'b1;
    wait_stb(n);
    checks++; if (n !== 595) begin errors++; $display("FAIL first_stb_edge got=%0d want=595", n); end
    checks++; if (audio_l !== 15'h3C00) begin errors++; $display("FAIL first_l got=%h want=3c00", audio_l); end
    checks++; if (audio_r !== 15'h3C00) begin errors++; $display("FAIL first_r got=%h want=3c00", audio_r); end
    step();
    checks++; if (sample_stb !== 1'b0) begin errors++; $display("FAIL stb_width got=%b want=0", sample_stb); end
    checks++; if (audio_l !== 15'h3C00) begin errors++; $display("FAIL hold_l got=%h want=3c00", audio_l); end
  endtask

  task automatic test_patterns();
    int pa0 [6] = '{0, 7, 15, 3, 1, 15};
    int pa1 [6] = '{0, 8, 0, 9, 2, 15};
    int n;
    logic [14:0] el, er;
    for (int p = 0; p < 6; p++) begin
      @(negedge clk);
      aud0 = 4'(pa0[p]);
      aud1 = 4'(pa1[p]);
      el = exp_l(pa0[p], pa1[p]);
      er = exp_r(pa0[p], pa1[p]);
      wait_stb(n);  // this window may still mix old and new inputs
      wait_stb(n);
      checks++; if (n != 594 && n != 595) begin errors++; $display("FAIL pat%0d_spacing got=%0d want=594/595", p, n); end
      checks++; if (audio_l !== el) begin errors++; $display("FAIL pat%0d_l got=%h want=%h", p, audio_l, el); end
      checks++; if (audio_r !== er) begin errors++; $display("FAIL pat%0d_r got=%h want=%h", p, audio_r, er); end
    end
  endtask

  task automatic test_rate_default();
    int m;
    bit prev;
    longint expect_edge;
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    m = 0;
    prev = 1'b0;
    for (int e = 1; e <= 7200; e++) begin
      step();
      if (sample_stb) begin
        m++;
        // Strobe m lands on the edge ceil(m*CLK/RATE) after release.
        expect_edge = (longint'(m) * 28542800 + 47999) / 48000;
        checks++; if (longint'(e) != expect_edge) begin errors++; $display("FAIL rate_stb%0d_edge got=%0d want=%0d", m, e, expect_edge); end
        checks++; if (prev) begin errors++; $display("FAIL rate_stb%0d_width got=2+ cycles want=1", m); end
      end
      prev = sample_stb;
    end
    checks++; if (m != 12) begin errors++; $display("FAIL rate_count got=%0d want=12", m); end
  endtask

  task automatic test_reset_mid();
    int n;
    @(negedge clk);
    aud0 = 4'd15;
    aud1 = 4'd15;
    wait_stb(n);
    wait_stb(n);
    repeat (300) step();
    #1;
    reset_n = 1'b0;
    #1;
    checks++; if (audio_l !== 15'd0) begin errors++; $display("FAIL midrst_l got=%h want=0", audio_l); end
    checks++; if (audio_r !== 15'd0) begin errors++; $display("FAIL midrst_r got=%h want=0", audio_r); end
    checks++; if (sample_stb !== 1'b0) begin errors++; $display("FAIL midrst_stb got=%b want=0", sample_stb); end
    @(negedge clk);
    reset_n = 1'b1;
    wait_stb(n);
    checks++; if (n !== 595) begin errors++; $display("FAIL midrst_first_edge got=%0d want=595", n); end
    checks++; if (audio_l !== 15'h3C00) begin errors++; $display("FAIL midrst_l_after got=%h want=3c00", audio_l); end
  endtask

  task automatic test_rate_small();
    int cnt;
    int last;
    @(negedge clk);
    rst_n_s = 1'b1;
    cnt = 0;
    last = 0;
    for (int k = 1; k <= 30000; k++) begin
      step();
      if (s_stb) begin
        cnt++;
        checks++; if (k - last != 600) begin errors++; $display("FAIL small_spacing%0d got=%0d want=600", cnt, k - last); end
        last = k;
      end
    end
    checks++; if (cnt != 50) begin errors++; $display("FAIL small_count got=%0d want=50", cnt); end
  endtask

  initial begin
    test_reset();
    test_first_strobe();
    test_patterns();
    test_rate_default();
    test_reset_mid();
    test_rate_small();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
